// File: rtl/fir_sched_pkg.sv
// FIR MAC scheduler shared types.
// State encoding and default geometry.
package fir_sched_pkg;

  localparam int PSZ_D  = 8;
  localparam int AGRW   = PSZ_D + 1;
  localparam int CLEN_D = 246;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACCQ = 3'd1,
    ACCI = 3'd2,
    DMPQ = 3'd3,
    DMPI = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over pending channels.
// Search starts one past the last winner.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] pending,
  input  logic [CHW-1:0] rr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx,
  output logic           valid
);

  // first pending channel after rr, wrapping
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      automatic logic [CHW-1:0] j =
        CHW'((int'(rr) + k) % NCH);
      if (!valid && pending[j]) begin
        valid  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shared I/Q FIR MAC job sequencer.
// Queues channel strobes, runs one job at a time.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int PSZ  = AGRW - 1,
  parameter int CLEN = CLEN_D
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NCH-1:0]         req_stb,
  input  logic [NCH*(PSZ+1)-1:0] req_ptr,
  input  logic [NCH-1:0]         ovr_clr,
  output logic [CHW-1:0]         r_chan,
  output logic [PSZ:0]           r_addr,
  output logic [PSZ-1:0]         c_addr,
  output logic                   mac_en,
  output logic                   dump,
  output logic [CHW-1:0]         dump_chan,
  output logic                   busy,
  output logic [NCH-1:0]         overrun
);

  localparam int AW = PSZ + 1;
  localparam logic [PSZ-1:0] CL = PSZ'(CLEN);

  state_t         state_q, state_d;
  logic [NCH-1:0] pending_q;
  logic [AW-1:0]  start_q [NCH];
  logic [CHW-1:0] rr_q, rr_d;

  logic [NCH-1:0] gnt;
  logic [NCH-1:0] gnt_now;
  logic [CHW-1:0] sel;
  logic           any;
  logic           grant;

  logic [CHW-1:0] r_chan_d;
  logic [AW-1:0]  r_addr_d;
  logic [PSZ-1:0] c_addr_d;
  logic           mac_en_d;
  logic           dump_d;
  logic [CHW-1:0] dump_chan_d;

  rr_arbiter #(
    .NCH(NCH),
    .CHW(CHW)
  ) u_arb (
    .pending(pending_q),
    .rr     (rr_q),
    .gnt    (gnt),
    .idx    (sel),
    .valid  (any)
  );

  assign gnt_now = grant ? gnt : '0;
  assign busy    = (state_q != IDLE);

  // per-channel request capture and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      overrun   <= '0;
      for (int i = 0; i < NCH; i++)
        start_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (req_stb[i] && (!pending_q[i] || gnt_now[i])) begin
          pending_q[i] <= 1'b1;
          start_q[i]   <= req_ptr[i*AW +: AW];
        end else if (gnt_now[i]) begin
          pending_q[i] <= 1'b0;
        end
        if (req_stb[i] && pending_q[i] && !gnt_now[i])
          overrun[i] <= 1'b1;
        else if (ovr_clr[i])
          overrun[i] <= 1'b0;
      end
    end
  end

  // job FSM and address counters: next values
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    r_chan_d    = r_chan;
    r_addr_d    = r_addr;
    c_addr_d    = c_addr;
    mac_en_d    = mac_en;
    dump_d      = dump;
    dump_chan_d = dump_chan;
    grant       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && any) begin
          grant    = 1'b1;
          r_chan_d = sel;
          r_addr_d = start_q[sel];
          c_addr_d = '0;
          mac_en_d = 1'b1;
          rr_d     = sel;
          state_d  = ACCQ;
        end
      end
      ACCQ: begin
        r_addr_d = r_addr - AW'(1);
        state_d  = ACCI;
      end
      ACCI: begin
        if (c_addr != CL) begin
          r_addr_d = r_addr - AW'(1);
          c_addr_d = c_addr + PSZ'(1);
          state_d  = ACCQ;
        end else begin
          mac_en_d    = 1'b0;
          dump_d      = 1'b1;
          dump_chan_d = r_chan;
          state_d     = DMPQ;
        end
      end
      DMPQ: state_d = DMPI;
      DMPI: begin
        dump_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        mac_en_d = 1'b0;
        dump_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // job FSM and address counters: registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= CHW'(NCH - 1);
      r_chan    <= '0;
      r_addr    <= '0;
      c_addr    <= '0;
      mac_en    <= 1'b0;
      dump      <= 1'b0;
      dump_chan <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      r_chan    <= r_chan_d;
      r_addr    <= r_addr_d;
      c_addr    <= c_addr_d;
      mac_en    <= mac_en_d;
      dump      <= dump_d;
      dump_chan <= dump_chan_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler.
// Directed scenarios plus random traffic vs a job-timeline model.
module tb_fir_mac_scheduler;
  import fir_sched_pkg::*;

  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int PSZ  = 8;
  localparam int CLEN = 246;
  localparam int AW   = AGRW;
  localparam int MACN = 2 * (CLEN + 1);
  localparam int JOB  = MACN + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [NCH-1:0]    req_stb = '0;
  logic [NCH*AW-1:0] req_ptr = '0;
  logic [NCH-1:0]    ovr_clr = '0;
  logic [CHW-1:0]    r_chan;
  logic [AW-1:0]     r_addr;
  logic [PSZ-1:0]    c_addr;
  logic              mac_en;
  logic              dump;
  logic [CHW-1:0]    dump_chan;
  logic              busy;
  logic [NCH-1:0]    overrun;

  fir_mac_scheduler #(
    .NCH(NCH), .CHW(CHW), .PSZ(PSZ), .CLEN(CLEN)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_stb(req_stb), .req_ptr(req_ptr),
    .ovr_clr(ovr_clr), .r_chan(r_chan),
    .r_addr(r_addr), .c_addr(c_addr),
    .mac_en(mac_en), .dump(dump),
    .dump_chan(dump_chan), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: pending/start/overrun per channel, job as a timeline
  bit            m_busy;
  int            t;
  int            m_chan, m_dchan, m_rr;
  logic [AW-1:0] m_start;
  bit            pend [NCH];
  logic [AW-1:0] st [NCH];
  bit            ovr [NCH];
  logic [AW-1:0] e_raddr;
  logic [PSZ-1:0] e_caddr;

  int n_mac, n_dump;
  bit prev_busy;
  int grants[$];
  int gaddr[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outv();
    return {4'b0, r_chan, r_addr, c_addr, mac_en, dump,
            dump_chan, busy, overrun};
  endfunction

  function automatic logic [31:0] expv();
    logic [NCH-1:0] ov;
    bit em, ed;
    for (int i = 0; i < NCH; i++) ov[i] = ovr[i];
    em = m_busy && (t < MACN);
    ed = m_busy && (t >= MACN);
    return {4'b0, CHW'(m_chan), e_raddr, e_caddr, em, ed,
            CHW'(m_dchan), m_busy, ov};
  endfunction

  task automatic model_edge();
    int g;
    bit po [NCH];
    if (reset) begin
      m_busy = 0; t = 0; m_chan = 0; m_dchan = 0;
      m_rr = NCH - 1; m_start = '0;
      e_raddr = '0; e_caddr = '0;
      for (int i = 0; i < NCH; i++) begin
        pend[i] = 0; st[i] = '0; ovr[i] = 0;
      end
      return;
    end
    g = -1;
    for (int i = 0; i < NCH; i++) po[i] = pend[i];
    if (!m_busy) begin
      if (en) begin
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_rr + k) % NCH;
          if (g < 0 && po[c]) g = c;
        end
      end
      if (g >= 0) begin
        m_busy = 1; t = 0; m_chan = g;
        m_start = st[g]; m_rr = g;
      end
    end else begin
      t++;
      if (t == MACN + 2) m_busy = 0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (req_stb[i]) begin
        if (!po[i] || g == i) begin
          pend[i] = 1;
          st[i] = req_ptr[i*AW +: AW];
        end else begin
          ovr[i] = 1;
        end
      end else if (g == i) begin
        pend[i] = 0;
      end
      if (!(req_stb[i] && po[i] && g != i) && ovr_clr[i])
        ovr[i] = 0;
    end
    if (m_busy) begin
      if (t < MACN) begin
        e_raddr = m_start - AW'(t);
        e_caddr = PSZ'(t / 2);
      end else begin
        e_raddr = m_start - AW'(MACN - 1);
        e_caddr = PSZ'(CLEN);
        m_dchan = m_chan;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", outv(), expv());
    if (mac_en) n_mac++;
    if (dump) n_dump++;
    if (busy && !prev_busy) begin
      grants.push_back(int'(r_chan));
      gaddr.push_back(int'(r_addr));
    end
    prev_busy = busy;
    req_stb = '0;
    ovr_clr = '0;
  endtask

  task automatic set_ptr(int ch, logic [AW-1:0] p);
    req_ptr[ch*AW +: AW] = p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    grants.delete();
    gaddr.delete();
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_idle(int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_out", outv(), 32'd0);
    en = 1'b1;

    // single job, ch0 at 0x0FF
    n_mac = 0; n_dump = 0;
    req_stb[0] = 1'b1; set_ptr(0, 9'h0FF);
    step();
    step();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_addr0", 32'(r_addr), 32'h0FF);
    step();
    chk("t1_addr1", 32'(r_addr), 32'h0FE);
    wait_idle(JOB);
    chk("t1_mac_cnt", 32'(n_mac), 32'd494);
    chk("t1_dump_cnt", 32'(n_dump), 32'd2);
    chk("t1_dchan", 32'(dump_chan), 32'd0);

    // round robin from reset
    do_reset();
    req_stb = '1;
    for (int i = 0; i < NCH; i++) set_ptr(i, AW'($urandom));
    step();
    run(4 * JOB + 4);
    chk("t2_n", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", 32'(grants[i]), 32'(i));
    grants.delete();
    req_stb = 4'b1010;
    step();
    run(2 * JOB + 4);
    chk("t2b_n", 32'(grants.size()), 32'd2);
    chk("t2b_first", 32'(grants[0]), 32'd1);
    chk("t2b_second", 32'(grants[1]), 32'd3);

    // overrun on ch2
    do_reset();
    req_stb[0] = 1'b1; set_ptr(0, 9'h100);
    step();
    req_stb[2] = 1'b1; set_ptr(2, 9'h055);
    step();
    chk("t3_no_ovr", 32'(overrun), 32'd0);
    req_stb[2] = 1'b1; set_ptr(2, 9'h0AA);
    step();
    chk("t3_ovr", 32'(overrun), 32'h4);
    wait_idle(JOB);
    step();
    chk("t3_ch", 32'(r_chan), 32'd2);
    chk("t3_start", 32'(r_addr), 32'h055);
    ovr_clr[2] = 1'b1;
    step();
    chk("t3_clr", 32'(overrun), 32'd0);
    wait_idle(JOB);

    // strobe on the grant cycle
    do_reset();
    req_stb[1] = 1'b1; set_ptr(1, 9'h010);
    step();
    req_stb[1] = 1'b1; set_ptr(1, 9'h020);
    step();
    chk("t4_ovr", 32'(overrun), 32'd0);
    run(2 * JOB + 4);
    chk("t4_n", 32'(grants.size()), 32'd2);
    chk("t4_a0", 32'(gaddr[0]), 32'h010);
    chk("t4_a1", 32'(gaddr[1]), 32'h020);
    chk("t4_ch", 32'(grants[1]), 32'd1);

    // address wrap
    do_reset();
    req_stb[3] = 1'b1; set_ptr(3, 9'h001);
    step();
    step();
    chk("t5_a0", 32'(r_addr), 32'h001);
    step();
    chk("t5_a1", 32'(r_addr), 32'h000);
    step();
    chk("t5_a2", 32'(r_addr), 32'h1FF);
    wait_idle(JOB);

    // en low mid-job, then reset mid-ACCI
    do_reset();
    req_stb[0] = 1'b1; set_ptr(0, 9'h080);
    step();
    run(11);
    en = 1'b0;
    req_stb[2] = 1'b1; set_ptr(2, 9'h033);
    step();
    chk("t6_still_busy", 32'(busy), 32'd1);
    wait_idle(JOB);
    run(5);
    chk("t6_hold", 32'(busy), 32'd0);
    en = 1'b1;
    step();
    chk("t6_grant", 32'(busy), 32'd1);
    chk("t6_grant_ch", 32'(r_chan), 32'd2);
    step();
    reset = 1'b1;
    step();
    chk("t6_rst", outv(), 32'd0);
    reset = 1'b0;
    step();
    chk("t6_after", outv(), 32'd0);

    // random traffic
    for (int c = 0; c < 24000; c++) begin
      en = ($urandom_range(15) != 0);
      reset = ($urandom_range(3999) == 0);
      for (int i = 0; i < NCH; i++) begin
        req_stb[i] = ($urandom_range(599) == 0);
        ovr_clr[i] = ($urandom_range(49) == 0);
        set_ptr(i, AW'($urandom));
      end
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
